// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory loader.
// Optional parity storage is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

  typedef enum logic {CLEAR, RUN} state_e;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 128;
  localparam int WORD_AW    = $clog2(DEPTH_DEF);
  localparam int BYTE_SH    = $clog2(DATA_W_DEF / 8);

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_array.sv
// 1R1W synchronous word storage; a read and a write of the same word
// in one cycle return the contents from before the write.
module imem_array #(
  parameter int W     = 16,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register only updates on a real read so the output holds otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with clear-on-reset sequencer, load port and fetch port.
// Defining IMEM_PARITY_EN adds a stored even-parity bit per word and F_PERR.
module imem_loader
  import imem_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 8,
  parameter int              DEPTH     = 128,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clr_i,
  output logic                       busy_o,
  input  logic                       ld_valid_i,
  output logic                       ld_ready_o,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr_i,
  input  logic [DATA_W-1:0]          ld_data_i,
  input  logic                       f_req_i,
  input  logic [ADDR_W-1:0]          f_addr_i,
  output logic                       f_valid_o,
  output logic [DATA_W-1:0]          f_data_o,
  output logic                       f_err_o,
  output logic                       f_perr_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SHIFT = $clog2(DATA_W / 8);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << SHIFT) - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             busy_q, ld_ready_q, f_valid_q, f_err_q, sel_init_q;

  logic [ADDR_W-1:0] f_idx;
  logic              f_bad, fetch_go, rd_en;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wword;
  logic [MEM_W-1:0]  wdata, rdata;

  assign f_idx    = f_addr_i >> SHIFT;
  assign f_bad    = (|(f_addr_i & LOW_MASK)) || ({1'b0, f_idx} >= DEPTH_L);
  assign fetch_go = f_req_i && (state_q == RUN);
  assign rd_en    = fetch_go && !f_bad;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wword = '0;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = cnt_q;
      wword = INIT_WORD;
    end else begin
      we    = ld_valid_i && ld_ready_q;
      waddr = ld_addr_i;
      wword = ld_data_i;
    end
  end

`ifdef IMEM_PARITY_EN
  assign wdata = {even_par(64'(wword)), wword};
`else
  assign wdata = wword;
`endif

  imem_array #(.W(MEM_W), .DEPTH(DEPTH), .AW(IDX_W)) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (rd_en),
    .raddr_i (f_idx[IDX_W-1:0]),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      ld_ready_q <= 1'b0;
      f_valid_q  <= 1'b0;
      f_err_q    <= 1'b0;
      sel_init_q <= 1'b0;
    end else begin
      f_valid_q <= fetch_go;
      f_err_q   <= fetch_go && f_bad;
      if (fetch_go) sel_init_q <= f_bad;
      case (state_q)
        CLEAR: begin
          if (clr_i) begin
            cnt_q <= '0;
          end else if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ld_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (clr_i) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign ld_ready_o = ld_ready_q;
  assign f_valid_o  = f_valid_q;
  assign f_err_o    = f_err_q;
  // Error responses return INIT_WORD without touching the read register.
  assign f_data_o   = sel_init_q ? INIT_WORD : rdata[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
  assign f_perr_o = f_valid_q && !sel_init_q &&
                    (rdata[DATA_W] != even_par(64'(rdata[DATA_W-1:0])));
`else
  assign f_perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed tables, multi-cycle sequences
// and a randomized run against a word-array reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        ld_valid = 1'b0;
  logic [6:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        f_req = 1'b0;
  logic [7:0]  f_addr = '0;
  logic        busy, ld_ready, f_valid, f_err, f_perr;
  logic [15:0] f_data;
  logic        b64, r64, v64, e64, p64;
  logic [15:0] d64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .f_req_i(f_req), .f_addr_i(f_addr),
    .f_valid_o(f_valid), .f_data_o(f_data), .f_err_o(f_err), .f_perr_o(f_perr)
  );

  imem_loader #(.DEPTH(64)) u64 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(b64),
    .ld_valid_i(1'b0), .ld_ready_o(r64), .ld_addr_i(6'd0),
    .ld_data_i(16'd0), .f_req_i(f_req), .f_addr_i(f_addr),
    .f_valid_o(v64), .f_data_o(d64), .f_err_o(e64), .f_perr_o(p64)
  );

  // Reference model: word array plus remaining clear cycles.
  logic [15:0] m_mem [128];
  bit          m_busy, m_valid, m_err;
  int          m_rem;
  logic [15:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 16'h0000;
    m_busy = 1; m_rem = 128; m_valid = 0; m_err = 0; m_last = 16'h0000;
  endtask

  task automatic model_edge();
    int idx;
    m_valid = 0; m_err = 0;
    if (m_busy) begin
      if (clr) m_rem = 128; else m_rem = m_rem - 1;
      if (m_rem == 0) m_busy = 0;
    end else begin
      if (f_req) begin
        idx = int'(f_addr) / 2;
        m_valid = 1;
        m_err = (f_addr % 2 != 0) || (idx >= 128);
        m_last = m_err ? 16'h0000 : m_mem[idx];
      end
      if (ld_valid) m_mem[ld_addr] = ld_data;
      if (clr) begin
        m_busy = 1; m_rem = 128;
        for (int i = 0; i < 128; i++) m_mem[i] = 16'h0000;
      end
    end
  endtask

  task automatic model_chk();
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ld_ready", 32'(ld_ready), 32'(!m_busy));
    chk("f_valid", 32'(f_valid), 32'(m_valid));
    chk("f_err", 32'(f_err), 32'(m_err));
    chk("f_data", 32'(f_data), 32'(m_last));
    chk("f_perr", 32'(f_perr), 32'd0);
  endtask

  task automatic idle();
    clr = 0; ld_valid = 0; ld_addr = '0; ld_data = '0; f_req = 0; f_addr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    model_chk();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    chk({tag, "_f_valid"}, 32'(f_valid), 32'd0);
    chk({tag, "_f_data"}, 32'(f_data), 32'd0);
    chk({tag, "_f_err"}, 32'(f_err), 32'd0);
    chk({tag, "_f_perr"}, 32'(f_perr), 32'd0);
  endtask

  task automatic wait_clear(input string name, input int exp_len);
    int n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(exp_len));
  endtask

  typedef struct {
    logic        ld_v;
    logic [6:0]  ld_a;
    logic [15:0] ld_d;
    logic        req;
    logic [7:0]  fa;
    logic        ev;
    logic        ee;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 7'd5,   16'hF001, 1'b0, 8'd0,   1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 7'd0,   16'h0000, 1'b1, 8'd10,  1'b1, 1'b0, 16'hF001};
    tbl[2] = '{1'b0, 7'd0,   16'h0000, 1'b1, 8'd11,  1'b1, 1'b1, 16'h0000};
    tbl[3] = '{1'b1, 7'd3,   16'h1234, 1'b1, 8'd6,   1'b1, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 7'd0,   16'h0000, 1'b1, 8'd6,   1'b1, 1'b0, 16'h1234};
    tbl[5] = '{1'b0, 7'd0,   16'h0000, 1'b0, 8'd0,   1'b0, 1'b0, 16'h1234};
    tbl[6] = '{1'b0, 7'd0,   16'h0000, 1'b1, 8'd255, 1'b1, 1'b1, 16'h0000};
    tbl[7] = '{1'b0, 7'd0,   16'h0000, 1'b1, 8'd254, 1'b1, 1'b0, 16'h0000};
    tbl[8] = '{1'b1, 7'd127, 16'hABCD, 1'b1, 8'd254, 1'b1, 1'b0, 16'h0000};
    tbl[9] = '{1'b0, 7'd0,   16'h0000, 1'b1, 8'd254, 1'b1, 1'b0, 16'hABCD};

    // Reset values and clear length after release
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1;
    wait_clear("clear_len_reset", 128);

    // Every word reads INIT_WORD after the clear
    for (int i = 0; i < 128; i++) begin
      f_req = 1; f_addr = 8'(2 * i);
      step();
      chk("sweep_err", 32'(f_err), 32'd0);
      chk("sweep_data", 32'(f_data), 32'd0);
    end
    idle();

    // Directed vectors: load, fetch, misalignment, read-before-write, hold
    for (int i = 0; i < 10; i++) begin
      ld_valid = tbl[i].ld_v; ld_addr = tbl[i].ld_a; ld_data = tbl[i].ld_d;
      f_req = tbl[i].req; f_addr = tbl[i].fa;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(f_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_err", i), 32'(f_err), 32'(tbl[i].ee));
      chk($sformatf("tbl%0d_data", i), 32'(f_data), 32'(tbl[i].ed));
    end
    idle();

    // Smaller instance flags an out-of-range index, accepts the last word
    f_req = 1; f_addr = 8'd200;
    @(posedge clk); #1; model_edge();
    chk("d64_far_valid", 32'(v64), 32'd1);
    chk("d64_far_err", 32'(e64), 32'd1);
    chk("d64_far_data", 32'(d64), 32'd0);
    f_addr = 8'd126;
    @(posedge clk); #1; model_edge();
    chk("d64_last_err", 32'(e64), 32'd0);
    chk("d64_last_valid", 32'(v64), 32'd1);
    idle();

    // CLR after loads: busy period with loads and fetches attempted
    clr = 1;
    step();
    clr = 0; ld_valid = 1; ld_addr = 7'd5; ld_data = 16'h7777; f_req = 1; f_addr = 8'd10;
    begin
      int n = 0;
      while (busy && n < 400) begin
        step();
        chk("clr_no_fetch", 32'(f_valid), 32'd0);
        n++;
      end
      chk("clear_len_clr", 32'(n), 32'd128);
    end
    idle();
    f_req = 1; f_addr = 8'd10;
    step();
    chk("post_clr_word5", 32'(f_data), 32'd0);
    idle();

    // CLR mid-clear restarts the count
    clr = 1; step(); clr = 0;
    repeat (20) step();
    clr = 1; step(); clr = 0;
    wait_clear("clear_len_restart", 128);

    // Reset mid-clear after a non-zero fetch
    ld_valid = 1; ld_addr = 7'd1; ld_data = 16'hBEEF;
    step();
    idle(); f_req = 1; f_addr = 8'd2;
    step();
    chk("beef_data", 32'(f_data), 32'h0000BEEF);
    idle(); clr = 1; step(); clr = 0;
    repeat (10) step();
    rst_n = 0;
    #1;
    chk_reset_vals("midclr_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    wait_clear("clear_len_rerst", 128);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      clr      = ($urandom_range(0, 499) == 0);
      ld_valid = $urandom_range(0, 1);
      ld_addr  = 7'($urandom);
      ld_data  = 16'($urandom);
      f_req    = ($urandom_range(0, 9) < 6);
      f_addr   = 8'($urandom);
      if ($urandom_range(0, 3) != 0) f_addr[0] = 1'b0;
      step();
    end
    idle();
    wait_clear("clear_len_tail", m_busy ? m_rem : 0);

`ifdef IMEM_PARITY_EN
    ld_valid = 1; ld_addr = 7'd7; ld_data = 16'h00F0;
    step();
    idle();
    dut.u_array.mem_q[7][0] = ~dut.u_array.mem_q[7][0];
    f_req = 1; f_addr = 8'd14;
    @(posedge clk); #1;
    chk("par_perr", 32'(f_perr), 32'd1);
    chk("par_data", 32'(f_data), 32'h000000F1);
    chk("par_valid", 32'(f_valid), 32'd1);
    idle();
`else
    ld_valid = 1; ld_addr = 7'd7; ld_data = 16'h00F0;
    step();
    idle(); f_req = 1; f_addr = 8'd14;
    step();
    chk("nopar_data", 32'(f_data), 32'h000000F0);
    chk("nopar_perr", 32'(f_perr), 32'd0);
    idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
